// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes (a - b) mod 2^WIDTH one bit per clock, LSB first,
// and presents the result with a one-cycle done pulse plus the final borrow.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             bin_q, bin_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             bout;
    logic             accept;
    logic [WIDTH-1:0] res_shifted;

    always_comb begin
        a_bit       = a_sr_q[0];
        b_bit       = b_sr_q[0];
        d_bit       = a_bit ^ b_bit ^ bin_q;
        bout        = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin_q);
        // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
        res_shifted = {d_bit, res_sr_q[WIDTH-1:1]};
        // DONE falls back to IDLE, or straight into a new operation when start is
        // already waiting, which gives the WIDTH+1 cycle back-to-back period.
        accept      = start && ((state_q == IDLE) || (state_q == DONE));

        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                res_sr_d = res_shifted;
                bin_d    = bout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    diff_d   = res_shifted;
                    borrow_d = bout;
                    state_d  = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: 4-bit and 8-bit instances checked cycle by cycle
// against an arithmetic reference ((a - b) mod 2^W, borrow = a < b, fixed latency).
module tb_serial_subtractor;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start4, start8;
    logic [3:0] a4, b4, diff4;
    logic [7:0] a8, b8, diff8;
    logic       busy4, done4, borrow4;
    logic       busy8, done8, borrow8;

    int checks   = 0;
    int failures = 0;

    // Last completed result per instance (index 0: WIDTH=4, index 1: WIDTH=8).
    int prev_diff[2];
    int prev_borrow[2];

    always #5 clock = ~clock;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clock  (clock),
        .resetn (resetn),
        .start  (start4),
        .a      (a4),
        .b      (b4),
        .busy   (busy4),
        .done   (done4),
        .diff   (diff4),
        .borrow (borrow4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clock  (clock),
        .resetn (resetn),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
        .borrow (borrow8)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic int idx(input int w);
        return (w == 4) ? 0 : 1;
    endfunction

    function automatic logic [31:0] get_busy(input int w);
        return (w == 4) ? 32'(busy4) : 32'(busy8);
    endfunction

    function automatic logic [31:0] get_done(input int w);
        return (w == 4) ? 32'(done4) : 32'(done8);
    endfunction

    function automatic logic [31:0] get_diff(input int w);
        return (w == 4) ? 32'(diff4) : 32'(diff8);
    endfunction

    function automatic logic [31:0] get_borrow(input int w);
        return (w == 4) ? 32'(borrow4) : 32'(borrow8);
    endfunction

    task automatic drive(input int w, input logic st, input logic [15:0] av, input logic [15:0] bv);
        if (w == 4) begin
            start4 = st;
            a4     = av[3:0];
            b4     = bv[3:0];
        end else begin
            start8 = st;
            a8     = av[7:0];
            b8     = bv[7:0];
        end
    endtask

    // One full operation: accept edge k, busy on k..k+w-1, done at k+w, idle again at k+w+1.
    task automatic do_op(input int w, input int av, input int bv);
        int m;
        int exp_d;
        int exp_b;
        int i;
        m     = 1 << w;
        exp_d = (av - bv + m) % m;
        exp_b = (av < bv) ? 1 : 0;
        i     = idx(w);
        @(negedge clock);
        drive(w, 1'b1, 16'(av), 16'(bv));
        @(posedge clock);
        #1;
        // Scramble operands right after acceptance; the result must not change.
        drive(w, 1'b0, 16'($urandom), 16'($urandom));
        for (int c = 0; c < w; c++) begin
            check($sformatf("w%0d busy a=%0d b=%0d c=%0d", w, av, bv, c), get_busy(w), 32'd1);
            check($sformatf("w%0d nodone a=%0d b=%0d c=%0d", w, av, bv, c), get_done(w), 32'd0);
            check($sformatf("w%0d hold_diff c=%0d", w, c), get_diff(w), 32'(prev_diff[i]));
            check($sformatf("w%0d hold_borrow c=%0d", w, c), get_borrow(w), 32'(prev_borrow[i]));
            @(posedge clock);
            #1;
        end
        check($sformatf("w%0d done a=%0d b=%0d", w, av, bv), get_done(w), 32'd1);
        check($sformatf("w%0d busy_at_done a=%0d b=%0d", w, av, bv), get_busy(w), 32'd0);
        check($sformatf("w%0d diff a=%0d b=%0d", w, av, bv), get_diff(w), 32'(exp_d));
        check($sformatf("w%0d borrow a=%0d b=%0d", w, av, bv), get_borrow(w), 32'(exp_b));
        prev_diff[i]   = exp_d;
        prev_borrow[i] = exp_b;
        @(posedge clock);
        #1;
        check($sformatf("w%0d done_pulse a=%0d b=%0d", w, av, bv), get_done(w), 32'd0);
        check($sformatf("w%0d diff_held a=%0d b=%0d", w, av, bv), get_diff(w), 32'(exp_d));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int av;
        int bv;
        prev_diff   = '{0, 0};
        prev_borrow = '{0, 0};
        resetn = 1'b0;
        drive(4, 1'b0, 16'd0, 16'd0);
        drive(8, 1'b0, 16'd0, 16'd0);
        #2;
        check("reset busy", 32'(busy4), 32'd0);
        check("reset done", 32'(done4), 32'd0);
        check("reset diff", 32'(diff4), 32'd0);
        check("reset borrow", 32'(borrow4), 32'd0);
        check("reset diff8", 32'(diff8), 32'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        // Directed WIDTH=4 cases.
        do_op(4, 9, 3);
        do_op(4, 3, 9);
        do_op(4, 0, 0);
        do_op(4, 15, 15);
        do_op(4, 0, 1);

        // start held high: accepts every WIDTH+1 cycles, operands toggled mid-SHIFT.
        @(negedge clock);
        drive(4, 1'b1, 16'd7, 16'd2);
        for (int e = 0; e <= 14; e++) begin
            @(posedge clock);
            #1;
            if ((e % 5) == 4) begin
                check($sformatf("stream done e=%0d", e), 32'(done4), 32'd1);
                check($sformatf("stream diff e=%0d", e), 32'(diff4), 32'd5);
                check($sformatf("stream borrow e=%0d", e), 32'(borrow4), 32'd0);
            end else begin
                check($sformatf("stream nodone e=%0d", e), 32'(done4), 32'd0);
                check($sformatf("stream busy e=%0d", e), 32'(busy4), 32'd1);
            end
            if ((e % 5) == 1) drive(4, 1'b1, 16'($urandom), 16'($urandom));
            if ((e % 5) == 3) drive(4, 1'b1, 16'd7, 16'd2);
            if (e == 14) drive(4, 1'b0, 16'd7, 16'd2);
        end
        prev_diff[0]   = 5;
        prev_borrow[0] = 0;
        @(posedge clock);
        #1;
        check("stream end done", 32'(done4), 32'd0);
        check("stream end busy", 32'(busy4), 32'd0);

        // Reset two cycles into SHIFT aborts the operation.
        @(negedge clock);
        drive(4, 1'b1, 16'd14, 16'd3);
        @(posedge clock);
        #1;
        drive(4, 1'b0, 16'd0, 16'd0);
        repeat (2) @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("abort busy", 32'(busy4), 32'd0);
        check("abort done", 32'(done4), 32'd0);
        check("abort diff", 32'(diff4), 32'd0);
        check("abort borrow", 32'(borrow4), 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clock);
            #1;
            check($sformatf("abort nodone c=%0d", c), 32'(done4), 32'd0);
            if (c == 1) resetn = 1'b1;
        end
        prev_diff   = '{0, 0};
        prev_borrow = '{0, 0};
        do_op(4, 12, 5);

        // WIDTH=8 directed cases.
        do_op(8, 8'h10, 8'h01);
        do_op(8, 8'h00, 8'hFF);

        // Random operations on both widths.
        for (int n = 0; n < 20; n++) begin
            av = int'($urandom_range(255, 0));
            bv = int'($urandom_range(255, 0));
            do_op(8, av, bv);
            do_op(4, av % 16, bv % 16);
        end

        // Exhaustive WIDTH=4 sweep in shuffled order of b per a.
        for (int x = 0; x < 16; x++) begin
            int off;
            off = int'($urandom_range(15, 0));
            for (int y = 0; y < 16; y++) begin
                do_op(4, x, (y + off) % 16);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
